// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// Shared types and defaults for the UART receive FIFO controller.
// Holds the receive handshake state encoding and the default FIFO depth.
package uart_rx_fifo_ctrl_pkg;

  localparam int DefaultDepth = 16;
  localparam int ByteWidth    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_ACK
  } rx_state_t;

  // The receiver is told to go only while we are waiting for or taking a byte.
  function automatic logic go_for(input rx_state_t s);
    return (s == ST_ARM) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_sync_fifo.sv
// Single-clock show-ahead FIFO: storage, wrapping pointers and a registered occupancy count.
// A push while full is only accepted when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(Depth));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Storage is deliberately left out of reset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side controller: handshakes bytes out of a UART receiver into a show-ahead FIFO.
// Tracks bytes dropped for lack of space in a sticky overrun flag.
module uart_rx_fifo_ctrl
  import uart_rx_fifo_ctrl_pkg::*;
#(
  parameter int Depth = DefaultDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   urx_go,
  input  logic [ByteWidth-1:0]   urx_data,
  input  logic                   urx_data_ready,
  input  logic                   rd_en,
  output logic [ByteWidth-1:0]   rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(Depth):0] count,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  rx_state_t state;
  rx_state_t next_state;
  logic      capture;
  logic      pop;
  logic      overrun_set;

  assign pop         = rd_en && !empty;
  assign overrun_set = capture && full && !pop;

  // urx_go is decoded from the next state so it flops alongside the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      urx_go <= 1'b0;
    end else begin
      state  <= next_state;
      urx_go <= go_for(next_state);
    end
  end

  // Once armed, a reception always runs to completion even if enable falls.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          next_state = ST_ARM;
        end
      end
      ST_ARM: begin
        if (urx_data_ready) begin
          next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        next_state = ST_ACK;
      end
      ST_ACK: begin
        if (!urx_data_ready) begin
          next_state = enable ? ST_ARM : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // A new drop beats a simultaneous clear so no lost byte goes unreported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .Width(ByteWidth),
    .Depth(Depth)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (capture),
    .push_data(urx_data),
    .pop      (pop),
    .pop_data (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl: a cycle table, directed corner sequences,
// and randomized traffic compared against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo_ctrl;

  localparam int Depth = 16;
  localparam int CW    = $clog2(Depth) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          urx_go;
  logic [7:0]    urx_data;
  logic          urx_data_ready;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          overrun_clr;

  always #5 clk = ~clk;

  uart_rx_fifo_ctrl #(.Depth(Depth)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .urx_go        (urx_go),
    .urx_data      (urx_data),
    .urx_data_ready(urx_data_ready),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
  );

  typedef struct {
    logic       en;
    logic       rdy;
    logic [7:0] dat;
    logic       rd;
    logic       clr;
    logic       go;
    int         cnt;
    logic       chk;
    logic [7:0] rdd;
  } vec_t;

  vec_t vecs[15];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q[$];
  logic       model_ovr;
  int         pend;
  logic [7:0] pend_byte;
  int         commits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    check("count", 32'(count), model_q.size());
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("full", 32'(full), 32'(model_q.size() == Depth));
    check("overrun", 32'(overrun), 32'(model_ovr));
    if (model_q.size() > 0) check("rd_data", 32'(rd_data), 32'(model_q[0]));
  endtask

  // One clock: the model applies the rules to the inputs that were present at the edge.
  task automatic applyStimulus();
    logic rd_pre, clr_pre, push, pop, ovr_set;
    rd_pre  = rd_en;
    clr_pre = overrun_clr;
    @(posedge clk);
    #1;
    push    = 1'b0;
    ovr_set = 1'b0;
    pop     = rd_pre && (model_q.size() > 0);
    if (pend > 0) begin
      pend--;
      push = (pend == 0);
    end
    if (pop) void'(model_q.pop_front());
    if (push) begin
      commits++;
      if (model_q.size() < Depth) model_q.push_back(pend_byte);
      else ovr_set = 1'b1;
    end
    if (ovr_set) model_ovr = 1'b1;
    else if (clr_pre) model_ovr = 1'b0;
    if (push) check("go_low_after_capture", 32'(urx_go), 32'd0);
    checkOutput();
  endtask

  // Receiver behaviour: offer a byte when told to go, withdraw once go drops.
  task automatic rx_drive(input logic want, input logic [7:0] b);
    if (urx_data_ready && !urx_go) begin
      urx_data_ready = 1'b0;
    end else if (!urx_data_ready && urx_go && want) begin
      urx_data_ready = 1'b1;
      urx_data       = b;
      pend_byte      = b;
      pend           = 2;
    end
  endtask

  task automatic rx_idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_drive(1'b0, 8'h00);
      applyStimulus();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pop_in_capture);
    int start;
    start = commits;
    for (int i = 0; i < 40 && commits == start; i++) begin
      rx_drive(1'b1, b);
      rd_en = pop_in_capture && (pend == 1);
      applyStimulus();
    end
    rd_en = 1'b0;
    if (commits == start) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_go();
    int n;
    n = 0;
    while (!urx_go && n < 20) begin
      applyStimulus();
      n++;
    end
    check("wait_go", 32'(urx_go), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < Depth + 2 && model_q.size() > 0; i++) begin
      rd_en = 1'b1;
      applyStimulus();
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // en rdy dat rd clr | go cnt chk rdd
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h41};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h41};
    vecs[5]  = '{1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1, 1'b1, 8'h41};
    vecs[6]  = '{1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h41};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2, 1'b1, 8'h41};
    vecs[8]  = '{1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 2, 1'b1, 8'h41};
    vecs[9]  = '{1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 3, 1'b1, 8'h41};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3, 1'b1, 8'h41};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b1, 8'h42};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h43};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h00};

    rst = 1'b1; enable = 1'b0; urx_data = 8'h00; urx_data_ready = 1'b0;
    rd_en = 1'b0; overrun_clr = 1'b0;
    model_ovr = 1'b0; pend = 0; pend_byte = 8'h00; commits = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_go", 32'(urx_go), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      enable = vecs[i].en; urx_data_ready = vecs[i].rdy; urx_data = vecs[i].dat;
      rd_en = vecs[i].rd; overrun_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_go", i), 32'(urx_go), 32'(vecs[i].go));
      check($sformatf("vec%0d_count", i), 32'(count), vecs[i].cnt);
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
      if (vecs[i].chk) check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rdd));
    end
    enable = 1'b0; urx_data_ready = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;

    // Fill past capacity: the seventeenth byte is dropped and flagged.
    enable = 1'b1;
    for (int b = 0; b < Depth + 1; b++) send_byte(8'(8'h10 + b), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), Depth);
    check("fill_overrun", 32'(overrun), 32'd1);

    overrun_clr = 1'b1;
    send_byte(8'hEE, 1'b0);
    overrun_clr = 1'b0;
    check("set_beats_clear", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    applyStimulus();
    overrun_clr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Full FIFO with a pop in the capture cycle accepts the byte without overrun.
    send_byte(8'hA5, 1'b1);
    check("full_pop_push_count", 32'(count), Depth);
    check("full_pop_push_overrun", 32'(overrun), 32'd0);
    drain();
    check("drained_empty", 32'(empty), 32'd1);

    // Ready held high for five cycles yields one push and go held low until it falls.
    rx_idle(3);
    wait_go();
    urx_data = 8'h77; pend_byte = 8'h77; urx_data_ready = 1'b1; pend = 2;
    applyStimulus();
    check("hs_go_capture", 32'(urx_go), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      check("hs_go_low", 32'(urx_go), 32'd0);
    end
    urx_data_ready = 1'b0;
    applyStimulus();
    check("hs_go_rearm", 32'(urx_go), 32'd1);

    // Enable falls while armed: the byte still lands, then the controller idles.
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      check("armed_hold_go", 32'(urx_go), 32'd1);
    end
    urx_data = 8'h5A; pend_byte = 8'h5A; urx_data_ready = 1'b1; pend = 2;
    applyStimulus();
    applyStimulus();
    urx_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      check("idle_go_low", 32'(urx_go), 32'd0);
    end
    drain();

    // Randomized traffic: slow consumer first to reach full, then a fast one.
    for (int c = 0; c < 600; c++) begin
      enable      = ($urandom_range(0, 7) != 0);
      rd_en       = (c < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      rx_drive($urandom_range(0, 3) != 0, 8'($urandom));
      applyStimulus();
    end
    rd_en = 1'b0; overrun_clr = 1'b0; enable = 1'b1;
    rx_idle(4);
    drain();

    // Reset in the middle of a reception with four bytes held.
    for (int b = 0; b < 4; b++) send_byte(8'(8'hC1 + b), 1'b0);
    rx_idle(3);
    wait_go();
    urx_data = 8'h99; pend_byte = 8'h99; urx_data_ready = 1'b1; pend = 2;
    applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_go", 32'(urx_go), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full", 32'(full), 32'd0);
    model_q.delete(); model_ovr = 1'b0; pend = 0; urx_data_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_go", 32'(urx_go), 32'd0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    check("resume_count", 32'(count), 32'd2);
    drain();
    check("resume_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
